// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - counter-based PWM generator; optional period-boundary duty latch via PWM_DUTY_LATCH_EN
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 7
`endif

module pwm_gen #(
  parameter int WIDTH = `BRIGHTNESS_WIDTH
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             i_enb,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_pwm,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] duty_eff;

  assign cnt_next = cnt + WIDTH'(1);

`ifdef PWM_DUTY_LATCH_EN
  // Duty is only taken from i_d at the wrap to 0, so pulses are never truncated.
  logic [WIDTH-1:0] duty_q;

  assign duty_eff = (cnt_next == '0) ? i_d : duty_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else if (i_enb) begin
      duty_q <= duty_eff;
    end
  end
`else
  assign duty_eff = i_d;
`endif

  // Parking the counter at all ones makes the first enabled edge start a period at 0.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt   <= '1;
      o_pwm <= 1'b0;
    end else if (!i_enb) begin
      cnt   <= '1;
      o_pwm <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      o_pwm <= (cnt_next < duty_eff);
    end
  end

  assign o_cnt = cnt;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
`timescale 1ns/1ps

module tb_pwm_gen;

  localparam int W = 7;
  localparam int P = 1 << W;

  logic         sysclk;
  logic         rst;
  logic         i_enb;
  logic [W-1:0] i_d;
  logic         o_pwm;
  logic [W-1:0] o_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_gen #(.WIDTH(W)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .i_enb  (i_enb),
    .i_d    (i_d),
    .o_pwm  (o_pwm),
    .o_cnt  (o_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    i_enb = 1'b0;
    i_d   = '0;
    #2;
    n_tests++;
    if (o_cnt !== 7'd127 || o_pwm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: cnt=%0d pwm=%b required cnt=127 pwm=0", o_cnt, o_pwm);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (o_cnt !== 7'd127 || o_pwm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: cnt=%0d pwm=%b required cnt=127 pwm=0", o_cnt, o_pwm);
    end
  endtask

  task automatic test_duty32();
    int highs = 0;
    i_enb = 1'b1;
    i_d   = 7'd32;
    for (int i = 0; i < P; i++) begin
      tick();
      highs += int'(o_pwm);
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== (i < 32)) begin
        n_fail++;
        $display("FAIL duty32 step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, (i < 32));
      end
    end
    n_tests++;
    if (highs !== 32) begin
      n_fail++;
      $display("FAIL duty32_highs: got %0d required 32", highs);
    end
  endtask

  task automatic test_duty_zero();
    i_d = 7'd0;
    for (int i = 0; i < P; i++) begin
      tick();
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== 1'b0) begin
        n_fail++;
        $display("FAIL duty0 step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=0", i, o_cnt, o_pwm, i);
      end
    end
  endtask

  task automatic test_duty_max();
    int highs = 0;
    i_d = 7'd127;
    for (int i = 0; i < P; i++) begin
      tick();
      highs += int'(o_pwm);
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== (i < 127)) begin
        n_fail++;
        $display("FAIL duty127 step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, (i < 127));
      end
    end
    n_tests++;
    if (highs !== 127) begin
      n_fail++;
      $display("FAIL duty127_highs: got %0d required 127", highs);
    end
  endtask

  task automatic test_enable_toggle();
    int highs = 0;
    i_d = 7'd64;
    for (int i = 0; i <= 10; i++) begin
      tick();
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== 1'b1) begin
        n_fail++;
        $display("FAIL toggle_pre step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=1", i, o_cnt, o_pwm, i);
      end
    end
    i_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (o_cnt !== 7'd127 || o_pwm !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle_off step %0d: cnt=%0d pwm=%b required cnt=127 pwm=0", i, o_cnt, o_pwm);
      end
    end
    i_enb = 1'b1;
    for (int i = 0; i < P; i++) begin
      tick();
      highs += int'(o_pwm);
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== (i < 64)) begin
        n_fail++;
        $display("FAIL toggle_post step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, (i < 64));
      end
    end
    n_tests++;
    if (highs !== 64) begin
      n_fail++;
      $display("FAIL toggle_highs: got %0d required 64", highs);
    end
  endtask

  task automatic test_duty_change();
    int  highs = 0;
    logic exp;
    i_d = 7'd32;
    for (int i = 0; i < P; i++) begin
      tick();
      if (i == 20) begin
        i_d = 7'd100;
      end
`ifdef PWM_DUTY_LATCH_EN
      exp = (i < 32);
`else
      exp = (i < 32) || (i >= 21 && i < 100);
`endif
      highs += int'(o_pwm);
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== exp) begin
        n_fail++;
        $display("FAIL change_cur step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, exp);
      end
    end
    n_tests++;
`ifdef PWM_DUTY_LATCH_EN
    if (highs !== 32) begin
      n_fail++;
      $display("FAIL change_cur_highs: got %0d required 32", highs);
    end
`else
    if (highs !== 100) begin
      n_fail++;
      $display("FAIL change_cur_highs: got %0d required 100", highs);
    end
`endif
    highs = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      highs += int'(o_pwm);
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== (i < 100)) begin
        n_fail++;
        $display("FAIL change_next step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, (i < 100));
      end
    end
    n_tests++;
    if (highs !== 100) begin
      n_fail++;
      $display("FAIL change_next_highs: got %0d required 100", highs);
    end
  endtask

  task automatic test_reset_mid_period();
    i_d = 7'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (o_cnt !== 7'd127 || o_pwm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: cnt=%0d pwm=%b required cnt=127 pwm=0", o_cnt, o_pwm);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (o_cnt !== W'(i) || o_pwm !== (i < 5)) begin
        n_fail++;
        $display("FAIL reset_release step %0d: cnt=%0d pwm=%b required cnt=%0d pwm=%b", i, o_cnt, o_pwm, i, (i < 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty32();
    test_duty_zero();
    test_duty_max();
    test_enable_toggle();
    test_duty_change();
    test_reset_mid_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
